sc_mul_sched: RTL and testbench

SC_MUL_SCHED -- requirements
Module: sc_mul_sched

---
 rtl/sc_sched_pkg.sv | 12 +
 rtl/sc_mul_core.sv | 28 ++
 rtl/sc_rr_arbiter.sv | 32 +++
 rtl/sc_mul_sched.sv | 123 ++++++++++++
 tb/tb_sc_mul_sched.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sc_sched_pkg.sv
// Shared types and helpers for the SC multiplier scheduler.
package sc_sched_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int SC_MUL_LAT_DEF = 2;

    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sc_mul_core.sv
// Pipelined unsigned multiplier core; product appears LAT cycles after a launch.
module sc_mul_core #(
    parameter int DW  = 8,
    parameter int OW  = 16,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [OW-1:0] o_p
);

    logic [OW-1:0] r_stage [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < LAT; s++) r_stage[s] <= '0;
        end else begin
            if (i_en) r_stage[0] <= OW'(i_a) * OW'(i_b);
            for (int s = 1; s < LAT; s++) r_stage[s] <= r_stage[s-1];
        end
    end

    assign o_p = r_stage[LAT-1];

endmodule

// File: rtl/sc_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last grant and wraps to 0.
module sc_rr_arbiter
    import sc_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_last,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IW-1:0]      o_idx
);

    logic w_found;
    int   w_j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_j = (int'(i_last) + k) % NUM_REQ;
            if (!w_found && i_req[w_j]) begin
                w_found      = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx        = IW'(w_j);
            end
        end
    end

endmodule

// File: rtl/sc_mul_sched.sv
// Shares one multiplier core among NUM_REQ requesters with round-robin grants.
// Optional: SC_SCHED_ZERO_BYPASS_EN short-circuits zero operands past the core.
module sc_mul_sched
    import sc_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 2*DATA_WIDTH,
    parameter int MUL_LAT    = SC_MUL_LAT_DEF,
    localparam int IW        = id_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [IW-1:0]                 rsp_id,
    output logic [OUT_WIDTH-1:0]          rsp_data,
    output logic                          busy
);

    state_t                r_state, w_next;
    logic [IW-1:0]         r_last, r_id, w_idx;
    logic [DATA_WIDTH-1:0] r_a, r_b;
    logic [3:0]            r_cnt;
    logic [OUT_WIDTH-1:0]  r_data, w_prod;
    logic [NUM_REQ-1:0]    w_grant;
    logic                  w_launch;
`ifdef SC_SCHED_ZERO_BYPASS_EN
    logic                  w_zero;
    assign w_zero = (r_a == '0) || (r_b == '0);
`endif

    sc_rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
        .i_req   (req_valid),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    sc_mul_core #(.DW(DATA_WIDTH), .OW(OUT_WIDTH), .LAT(MUL_LAT)) u_core (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_launch),
        .i_a  (r_a),
        .i_b  (r_b),
        .o_p  (w_prod)
    );

    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        w_launch  = 1'b0;
        case (r_state)
            IDLE: if (|req_valid) begin
                req_ready = w_grant;
                w_next    = ISSUE;
            end
            ISSUE: begin
`ifdef SC_SCHED_ZERO_BYPASS_EN
                if (w_zero) begin
                    w_next = RESP;
                end else begin
                    w_launch = 1'b1;
                    w_next   = WAIT;
                end
`else
                w_launch = 1'b1;
                w_next   = WAIT;
`endif
            end
            WAIT: if (r_cnt == '0) w_next = RESP;
            RESP: if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Reset priority starts at requester 0 because last_grant points at the top index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= IW'(NUM_REQ-1);
            r_id   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_data <= '0;
        end else begin
            case (r_state)
                IDLE: if (|req_valid) begin
                    r_a  <= req_a[w_idx*DATA_WIDTH +: DATA_WIDTH];
                    r_b  <= req_b[w_idx*DATA_WIDTH +: DATA_WIDTH];
                    r_id <= w_idx;
                end
                ISSUE: begin
                    r_cnt <= 4'(MUL_LAT-1);
`ifdef SC_SCHED_ZERO_BYPASS_EN
                    if (w_zero) r_data <= '0;
`endif
                end
                WAIT: begin
                    if (r_cnt == '0) r_data <= w_prod;
                    else             r_cnt  <= r_cnt - 4'd1;
                end
                RESP: if (rsp_ready) r_last <= r_id;
                default: ;
            endcase
        end
    end

    assign rsp_valid = (r_state == RESP);
    assign rsp_data  = r_data;
    assign rsp_id    = r_id;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_sc_mul_sched.sv
// Self-checking bench: transaction-level model of grants/latency plus directed scenarios.
module tb_sc_mul_sched;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int OW  = 16;
    localparam int LAT = 2;
`ifdef SC_SCHED_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk, rst;
    logic [N-1:0]    req_valid, req_ready;
    logic [N*DW-1:0] req_a, req_b;
    logic            rsp_valid, rsp_ready, busy;
    logic [1:0]      rsp_id;
    logic [OW-1:0]   rsp_data;

    sc_mul_sched #(.NUM_REQ(N), .DATA_WIDTH(DW), .OUT_WIDTH(OW), .MUL_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0, errors = 0, cyc = 0;
    bit          m_busy = 1'b0;
    int          m_last = N-1, m_id = 0, m_due = 0;
    logic [OW-1:0] m_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    // Model: one transaction in flight; response due a fixed number of cycles after grant.
    task automatic compare();
        int g;
        logic [DW-1:0] a, b;
        bit ev;
        cyc++;
        if (rst) begin
            chk("rst_busy", busy, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_rsp_id", rsp_id, 0);
            m_busy = 1'b0;
            m_last = N-1;
            return;
        end
        chk("busy", busy, m_busy);
        if (!m_busy) begin
            g = rr_pick(req_valid, m_last);
            chk("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
            chk("rsp_valid_idle", rsp_valid, 0);
            if (g >= 0) begin
                a      = req_a[g*DW +: DW];
                b      = req_b[g*DW +: DW];
                m_busy = 1'b1;
                m_id   = g;
                m_data = OW'(int'(a) * int'(b));
                m_due  = cyc + ((BYP && (a == 0 || b == 0)) ? 2 : LAT + 2);
            end
        end else begin
            chk("req_ready_busy", req_ready, 0);
            ev = (cyc >= m_due);
            chk("rsp_valid", rsp_valid, ev);
            if (ev) begin
                chk("rsp_data", rsp_data, m_data);
                chk("rsp_id", rsp_id, m_id);
                if (rsp_ready) begin
                    m_busy = 1'b0;
                    m_last = m_id;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        req_valid = '0;
        rsp_ready = 1'b1;
        while (busy && n < 30) begin
            tick();
            n++;
        end
        if (busy) chk("drain_timeout", 1, 0);
    endtask

    initial begin
        int order[5];
        int exp_order[5];
        int got, n;
        exp_order = '{0, 1, 2, 3, 0};
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
        #1;
        tick();
        tick();
        rst = 1'b0;

        // Single request from requester 2: 0x30*0x05 = 0xF0
        req_valid = 4'b0100;
        req_a[2*DW +: DW] = 8'h30;
        req_b[2*DW +: DW] = 8'h05;
        #1;
        chk("single_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("single_not_yet", rsp_valid, 0);
        tick();
        chk("single_valid", rsp_valid, 1);
        chk("single_data", rsp_data, 16'h00F0);
        chk("single_id", rsp_id, 2);
        drain();

        // Fairness from reset priority
        do_reset();
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        req_a = 32'h04030201;
        req_b = 32'h0A0B0C0D;
        got = 0;
        for (int t = 0; t < 60 && got < 5; t++) begin
            #1;
            if (req_ready != 0) begin
                for (int i = 0; i < N; i++) if (req_ready[i]) order[got] = i;
                got++;
            end
            tick();
        end
        chk("fair_count", got, 5);
        for (int i = 0; i < 5; i++) chk("fair_order", order[i], exp_order[i]);
        drain();

        // Backpressure: 0x11*0x0F = 0xFF held for 10 cycles
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        req_a[0 +: DW] = 8'h11;
        req_b[0 +: DW] = 8'h0F;
        tick();
        req_valid = 4'b0010;
        n = 0;
        while (!rsp_valid && n < 10) begin
            tick();
            n++;
        end
        chk("bp_rsp_seen", rsp_valid, 1);
        for (int t = 0; t < 10; t++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_data", rsp_data, 16'h00FF);
            chk("bp_id", rsp_id, 0);
            chk("bp_ready", req_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_no_grant_hs", req_ready, 0);
        tick();
        rsp_ready = 1'b0;
        chk("bp_next_grant", req_ready, 4'b0010);
        drain();

        // Zero operand
        req_valid = 4'b1000;
        rsp_ready = 1'b0;
        req_a[3*DW +: DW] = 8'h00;
        req_b[3*DW +: DW] = 8'hA7;
        #1;
        chk("zero_ready", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        n = 1;
        while (!rsp_valid && n < 10) begin
            tick();
            n++;
        end
        chk("zero_latency", n, BYP ? 2 : 4);
        chk("zero_data", rsp_data, 0);
        drain();

        // Reset during WAIT
        req_valid = 4'b0001;
        req_a[0 +: DW] = 8'h20;
        req_b[0 +: DW] = 8'h03;
        rsp_ready = 1'b1;
        tick();
        req_valid = '0;
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", rsp_valid, 0);
        chk("midrst_data", rsp_data, 0);
        tick();
        rst = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("midrst_grant", req_ready, 4'b0001);
        for (int t = 0; t < 12; t++) tick();

        // Randomized traffic against the model
        for (int t = 0; t < 400; t++) begin
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_a[i*DW +: DW] = ($urandom_range(0, 4) == 0) ? 8'h00 : DW'($urandom);
                req_b[i*DW +: DW] = ($urandom_range(0, 4) == 0) ? 8'h00 : DW'($urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
